// File: rtl/dif_lut_pkg.sv
// Shared definitions for the DIF-LUT feeder: default widths, key limits and
// the clamp helper that turns a rounded, shifted sample into {sat, key}.
package dif_lut_pkg;

  localparam int DEF_IN_W   = 16;
  localparam int DEF_KEY_W  = 10;
  localparam int DEF_WORD_W = 12;

  localparam logic signed [DEF_KEY_W-1:0] KEY_MAX = 10'sb01_1111_1111;
  localparam logic signed [DEF_KEY_W-1:0] KEY_MIN = 10'sb10_0000_0000;

  // Clamp a quantised sample into the signed key range; MSB of the result
  // flags that the clamp changed the value.
  function automatic logic [DEF_KEY_W:0] sat_key(input logic signed [DEF_IN_W:0] q);
    logic [DEF_KEY_W:0] r;
    if (q > $signed((DEF_IN_W+1)'(KEY_MAX))) begin
      r = {1'b1, KEY_MAX};
    end else if (q < $signed((DEF_IN_W+1)'(KEY_MIN))) begin
      r = {1'b1, KEY_MIN};
    end else begin
      r = {1'b0, q[DEF_KEY_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/dif_lut_quant.sv
// Combinational quantiser: round half-up, arithmetic shift by SHIFT, then
// clamp to the signed KEY_W range. Works one bit wider than the input so the
// rounding offset can never overflow.
import dif_lut_pkg::*;

module dif_lut_quant #(
  parameter int IN_W  = DEF_IN_W,
  parameter int KEY_W = DEF_KEY_W,
  parameter int SHIFT = 4
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [KEY_W-1:0] key,
  output logic             sat
);

  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ($signed({{IN_W{1'b0}}, 1'b1}) <<< RS) : '0;
  localparam logic signed [IN_W:0] KMAX =
    $signed({{(IN_W+2-KEY_W){1'b0}}, {(KEY_W-1){1'b1}}});
  localparam logic signed [IN_W:0] KMIN = ~KMAX;

  logic signed [IN_W:0] t;
  logic signed [IN_W:0] q;

  // Add the half-LSB rounding offset and floor-shift away the fraction.
  always_comb begin
    t = $signed({in_data[IN_W-1], in_data}) + RND;
    q = t >>> SHIFT;
  end

  generate
    if (IN_W == DEF_IN_W && KEY_W == DEF_KEY_W) begin : g_pkg
      // Default geometry: reuse the shared clamp helper.
      always_comb begin
        {sat, key} = sat_key(q);
      end
    end else begin : g_gen
      // Other geometries: same clamp against width-derived limits.
      always_comb begin
        if (q > KMAX) begin
          key = KMAX[KEY_W-1:0];
          sat = 1'b1;
        end else if (q < KMIN) begin
          key = KMIN[KEY_W-1:0];
          sat = 1'b1;
        end else begin
          key = q[KEY_W-1:0];
          sat = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/dif_lut_feeder.sv
// Two-stage valid/ready wrapper around an external combinational DIF-LUT.
// Stage 1 holds the quantised key (driven straight to the LUT), stage 2
// registers the LUT result. Ready ripples back combinationally, so the
// pipe runs at one sample per clock with no bubble.
// Optional build macro DIF_LUT_FEEDER_STATS_EN adds a saturating counter of
// clamped inputs (sat_count) with a synchronous clear (clr_stats).
import dif_lut_pkg::*;

module dif_lut_feeder #(
  parameter int IN_W   = DEF_IN_W,
  parameter int KEY_W  = DEF_KEY_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic [KEY_W-1:0]  lut_key,
  input  logic [WORD_W-1:0] lut_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_sat
`ifdef DIF_LUT_FEEDER_STATS_EN
  ,
  input  logic              clr_stats,
  output logic [15:0]       sat_count
`endif
);

  logic [KEY_W-1:0] q_key;
  logic             q_sat;
  logic             s1_valid;
  logic [KEY_W-1:0] key_r;
  logic             sat_r;
  logic             adv;
  logic             accept;

  dif_lut_quant #(
    .IN_W  (IN_W),
    .KEY_W (KEY_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .in_data (in_data),
    .key     (q_key),
    .sat     (q_sat)
  );

  // Handshake: stage 1 moves on when stage 2 is empty or draining this cycle.
  always_comb begin
    adv      = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || adv;
    accept   = in_valid && in_ready;
  end

  assign lut_key = key_r;

  // Stage 1: capture the quantised key; it stays put while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      key_r    <= '0;
      sat_r    <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      key_r    <= q_key;
      sat_r    <= q_sat;
    end else if (adv) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= s1_valid;
    end
  end

  // Stage 2: register the LUT result and hold it until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= 1'b1;
      out_data  <= lut_value;
      out_sat   <= sat_r;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef DIF_LUT_FEEDER_STATS_EN
  // Count accepted samples whose key was clamped; sticks at all-ones, clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= 16'h0000;
    end else if (clr_stats) begin
      sat_count <= 16'h0000;
    end else if (accept && q_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'h0001;
    end else begin
      sat_count <= sat_count;
    end
  end
`endif

endmodule
